id_tracker: RTL and testbench
=============================

ID_TRACKER -- requirements
Module: id_tracker

Interface
REQ-001 SHALL have parameter NumEntries, default 4, number of tracked-ID table entries.
REQ-002 SHALL have parameter IdWidth, default 4, AXI ID width.
REQ-003 SHALL have parameter CntWidth, default 3, width of per-entry outstanding counter.
REQ-004 SHALL have parameter TimerWidth, default 8, width of per-entry budget timer.
REQ-005 SHALL have parameter Budget, default 16, timer reload value in cycles (1 to 2^TimerWidth-1).
REQ-006 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have ports: req_valid_i  in  1  new transaction issued; req_id_i  in  IdWidth  its ID; req_ready_o  out  1  tracker can accept it.
REQ-008 SHALL have ports: rsp_valid_i  in  1  final response beat seen; rsp_id_i  in  IdWidth  its ID.
REQ-009 SHALL have ports: timeout_o  out  1  one-cycle pulse, entry budget expired; timeout_id_o  out  IdWidth  ID of expired entry.
REQ-010 SHALL have ports: unexp_rsp_o  out  1  one-cycle pulse, response matched no live entry; full_o  out  1  no free entry.

Function
REQ-011 Each entry SHALL hold id, free, cnt (CntWidth), timer (TimerWidth).
REQ-012 Entry i SHALL "match" an ID when !free and entry id equals that ID; at most one entry matches any ID.
REQ-013 req_ready_o SHALL be combinational: if req_id_i matches entry i then (cnt_i != 2^CntWidth-1), else (any entry free); independent of req_valid_i.
REQ-014 Accept (req_valid_i && req_ready_o) on matching entry SHALL increment cnt; timer unchanged.
REQ-015 Accept with no match SHALL allocate the lowest-index free entry: id=req_id_i, free=0, cnt=1, timer=Budget.
REQ-016 rsp_valid_i on matching entry SHALL decrement cnt and reload timer=Budget; if cnt becomes 0 the entry SHALL become free.
REQ-017 rsp_valid_i with no match SHALL assert unexp_rsp_o for exactly one cycle after the edge; no state change.
REQ-018 Accept and response to same matching entry in same cycle SHALL leave cnt unchanged, reload timer, keep entry allocated (even when cnt==1).
REQ-019 Free vector for allocation SHALL be the registered state; an entry freed this cycle is not reusable until next cycle.
REQ-020 Each non-free entry SHALL decrement timer every cycle while timer>0 and no reload occurs; timer holds at 0.
REQ-021 Timer transition 1->0 SHALL produce timeout_o=1 for one cycle in the following cycle, timeout_id_o = id of lowest-index entry expiring that cycle; entry stays allocated.
REQ-022 Response to an expired entry SHALL be handled per REQ-016 without unexp_rsp_o.
REQ-023 full_o SHALL be registered-state-derived: 1 when no entry free.
REQ-024 All state updates SHALL take effect at the next rising clk_i edge; timeout_o, timeout_id_o, unexp_rsp_o registered.

Reset
REQ-025 rst_i high SHALL asynchronously set all entries free, cnt=0, timer=0, id=0.
REQ-026 During and after reset: timeout_o=0, timeout_id_o=0, unexp_rsp_o=0, full_o=0, req_ready_o=1.
REQ-027 Reset mid-operation SHALL discard all outstanding tracking; no timeout or error pulse due to discarded entries.

Structure
REQ-028 Entry struct type (id, free, cnt, timer) and default parameter constants SHALL live in shared package axi_monitor_pkg.
REQ-029 One sub-module id_tracker_entry SHALL implement a single entry's registers, match compare and timer; id_tracker instantiates NumEntries of them plus allocation priority encoder.

Verification
REQ-030 Reset, then accept ID 3 -> entry0 id=3 cnt=1; rsp ID 3 -> entry0 free, full_o=0.
REQ-031 Accept IDs 1,2,3,4 then ID 5 -> full_o=1, req_ready_o=0 for ID 5, req_ready_o=1 for ID 2.
REQ-032 Accept ID 7 seven times (CntWidth=3) -> req_ready_o=0 for ID 7; one rsp ID 7 -> req_ready_o=1.
REQ-033 Accept ID 2, no rsp for 16 cycles (Budget=16) -> timeout_o single pulse, timeout_id_o=2; later rsp ID 2 -> entry freed, no unexp_rsp_o.
REQ-034 Rsp ID 9 with table empty -> unexp_rsp_o one-cycle pulse, state unchanged.
REQ-035 ID 6 cnt=1, same-cycle accept and rsp ID 6 -> cnt stays 1, entry allocated, timer=Budget; assert rst_i mid-sequence -> all outputs at reset values, no pulses.

Source files
------------

// File: rtl/axi_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_monitor_pkg
// Description : Shared constants and types for the AXI monitor blocks.
//               Holds the default configuration of the ID tracker and the
//               packed view of one tracker entry (id, free, cnt, timer) at
//               those default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_monitor_pkg;

    localparam int C_DEF_NUM_ENTRIES = 4;
    localparam int C_DEF_ID_WIDTH    = 4;
    localparam int C_DEF_CNT_WIDTH   = 3;
    localparam int C_DEF_TIMER_WIDTH = 8;
    localparam int C_DEF_BUDGET      = 16;

    // One tracked-ID table entry at the default widths.
    typedef struct packed {
        logic [C_DEF_ID_WIDTH-1:0]    id;
        logic                         free;
        logic [C_DEF_CNT_WIDTH-1:0]   cnt;
        logic [C_DEF_TIMER_WIDTH-1:0] timer;
    } entry_t;

endpackage : axi_monitor_pkg
`default_nettype wire

// File: rtl/id_tracker_entry.sv
`default_nettype none
// ============================================================================
// Module      : id_tracker_entry
// Description : One entry of the outstanding-ID table. Holds the ID, free
//               flag, outstanding counter and budget timer, and performs the
//               request/response ID compares for this entry.
// Ports       : clk_i, rst_i      - clock, async active-high reset
//               i_req_id          - ID of the incoming request
//               i_rsp_id          - ID of the incoming final response
//               i_accept          - a request is accepted this cycle
//               i_rsp_valid       - a final response is seen this cycle
//               i_alloc           - allocate this (free) entry to i_req_id
//               o_free            - entry is free (registered)
//               o_req_match       - entry is live and holds i_req_id
//               o_rsp_match       - entry is live and holds i_rsp_id
//               o_cnt_max         - outstanding counter is saturated
//               o_expire          - timer goes 1 -> 0 at the next edge
//               o_id              - stored ID
// Revision    : 1.0 - initial release
// ============================================================================
module id_tracker_entry
    import axi_monitor_pkg::*;
#(
    parameter int IdWidth    = C_DEF_ID_WIDTH,
    parameter int CntWidth   = C_DEF_CNT_WIDTH,
    parameter int TimerWidth = C_DEF_TIMER_WIDTH,
    parameter int Budget     = C_DEF_BUDGET
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [IdWidth-1:0] i_req_id,
    input  logic [IdWidth-1:0] i_rsp_id,
    input  logic               i_accept,
    input  logic               i_rsp_valid,
    input  logic               i_alloc,
    output logic               o_free,
    output logic               o_req_match,
    output logic               o_rsp_match,
    output logic               o_cnt_max,
    output logic               o_expire,
    output logic [IdWidth-1:0] o_id
);

    localparam logic [TimerWidth-1:0] c_BUDGET    = TimerWidth'(Budget);
    localparam logic [TimerWidth-1:0] c_TIMER_ONE = TimerWidth'(1);
    localparam logic [CntWidth-1:0]   c_CNT_ONE   = CntWidth'(1);

    logic [IdWidth-1:0]    r_id;
    logic                  r_free;
    logic [CntWidth-1:0]   r_cnt;
    logic [TimerWidth-1:0] r_timer;

    logic w_req_match;
    logic w_rsp_match;
    logic w_inc;
    logic w_dec;

    assign w_req_match = !r_free && (r_id == i_req_id);
    assign w_rsp_match = !r_free && (r_id == i_rsp_id);
    assign w_inc       = i_accept && w_req_match;
    assign w_dec       = i_rsp_valid && w_rsp_match;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_id    <= '0;
            r_free  <= 1'b1;
            r_cnt   <= '0;
            r_timer <= '0;
        end else if (i_alloc) begin
            // Only ever asserted while free, so no match/response can collide.
            r_id    <= i_req_id;
            r_free  <= 1'b0;
            r_cnt   <= c_CNT_ONE;
            r_timer <= c_BUDGET;
        end else if (!r_free) begin
            unique case ({w_inc, w_dec})
                2'b10: begin
                    // A new request does not refresh the budget.
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (r_timer != '0) begin
                        r_timer <= r_timer - c_TIMER_ONE;
                    end
                end
                2'b01: begin
                    r_cnt   <= r_cnt - c_CNT_ONE;
                    r_timer <= c_BUDGET;
                    if (r_cnt == c_CNT_ONE) begin
                        r_free <= 1'b1;
                    end
                end
                2'b11: begin
                    // Issue and retire cancel out; entry stays live even at cnt==1.
                    r_timer <= c_BUDGET;
                end
                default: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - c_TIMER_ONE;
                    end
                end
            endcase
        end
    end

    assign o_free      = r_free;
    assign o_req_match = w_req_match;
    assign o_rsp_match = w_rsp_match;
    assign o_cnt_max   = (r_cnt == '1);
    // A response this cycle reloads the timer, which cancels the expiry.
    assign o_expire    = !r_free && (r_timer == c_TIMER_ONE) && !w_dec;
    assign o_id        = r_id;

endmodule : id_tracker_entry
`default_nettype wire

// File: rtl/id_tracker.sv
`default_nettype none
// ============================================================================
// Module      : id_tracker
// Description : Tracks outstanding AXI transaction IDs in a small table.
//               Counts outstanding transactions per ID, flags responses that
//               match no live entry and flags entries whose response budget
//               has run out.
// Ports       : clk_i, rst_i      - clock, async active-high reset
//               req_valid_i/id_i  - new transaction issued, and its ID
//               req_ready_o       - tracker can accept that ID (combinational)
//               rsp_valid_i/id_i  - final response beat seen, and its ID
//               timeout_o         - one-cycle pulse, an entry budget expired
//               timeout_id_o      - ID of the lowest-index expired entry
//               unexp_rsp_o       - one-cycle pulse, response hit no entry
//               full_o            - no free entry
// Revision    : 1.0 - initial release
// ============================================================================
module id_tracker
    import axi_monitor_pkg::*;
#(
    parameter int NumEntries = C_DEF_NUM_ENTRIES,
    parameter int IdWidth    = C_DEF_ID_WIDTH,
    parameter int CntWidth   = C_DEF_CNT_WIDTH,
    parameter int TimerWidth = C_DEF_TIMER_WIDTH,
    parameter int Budget     = C_DEF_BUDGET
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    input  logic [IdWidth-1:0] req_id_i,
    output logic               req_ready_o,
    input  logic               rsp_valid_i,
    input  logic [IdWidth-1:0] rsp_id_i,
    output logic               timeout_o,
    output logic [IdWidth-1:0] timeout_id_o,
    output logic               unexp_rsp_o,
    output logic               full_o
);

    logic [NumEntries-1:0] w_free;
    logic [NumEntries-1:0] w_req_match;
    logic [NumEntries-1:0] w_rsp_match;
    logic [NumEntries-1:0] w_cnt_max;
    logic [NumEntries-1:0] w_expire;
    logic [NumEntries-1:0] w_alloc;
    logic [IdWidth-1:0]    w_id [NumEntries];

    logic               w_any_match;
    logic               w_ready;
    logic               w_accept;
    logic               w_new;
    logic               w_alloc_found;
    logic               w_exp_found;
    logic [IdWidth-1:0] w_exp_id;

    logic               r_timeout;
    logic [IdWidth-1:0] r_timeout_id;
    logic               r_unexp;

    generate
        for (genvar gi = 0; gi < NumEntries; gi++) begin : g_entry
            id_tracker_entry #(
                .IdWidth    (IdWidth),
                .CntWidth   (CntWidth),
                .TimerWidth (TimerWidth),
                .Budget     (Budget)
            ) u_entry (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .i_req_id    (req_id_i),
                .i_rsp_id    (rsp_id_i),
                .i_accept    (w_accept),
                .i_rsp_valid (rsp_valid_i),
                .i_alloc     (w_alloc[gi]),
                .o_free      (w_free[gi]),
                .o_req_match (w_req_match[gi]),
                .o_rsp_match (w_rsp_match[gi]),
                .o_cnt_max   (w_cnt_max[gi]),
                .o_expire    (w_expire[gi]),
                .o_id        (w_id[gi])
            );
        end
    endgenerate

    // A live ID is limited by its counter; a new ID needs any free slot.
    assign w_any_match = |w_req_match;
    assign w_ready     = w_any_match ? !(|(w_req_match & w_cnt_max)) : (|w_free);
    assign w_accept    = req_valid_i && w_ready;
    assign w_new       = w_accept && !w_any_match;

    // Lowest-index free entry wins; uses registered free flags only, so an
    // entry released this cycle is not reused until the next one.
    always_comb begin
        w_alloc       = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (w_free[i] && !w_alloc_found) begin
                w_alloc[i]    = w_new;
                w_alloc_found = 1'b1;
            end
        end
    end

    // Lowest-index entry expiring this cycle supplies the reported ID.
    always_comb begin
        w_exp_id    = '0;
        w_exp_found = 1'b0;
        for (int i = 0; i < NumEntries; i++) begin
            if (w_expire[i] && !w_exp_found) begin
                w_exp_id    = w_id[i];
                w_exp_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout    <= 1'b0;
            r_timeout_id <= '0;
            r_unexp      <= 1'b0;
        end else begin
            r_timeout    <= w_exp_found;
            r_timeout_id <= w_exp_id;
            r_unexp      <= rsp_valid_i && !(|w_rsp_match);
        end
    end

    assign req_ready_o  = w_ready;
    assign timeout_o    = r_timeout;
    assign timeout_id_o = r_timeout_id;
    assign unexp_rsp_o  = r_unexp;
    assign full_o       = !(|w_free);

endmodule : id_tracker
`default_nettype wire

// File: tb/tb_id_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_tracker
// Description : Self-checking bench for id_tracker (default parameters).
//               A table of directed vectors plus hand-written sequences for
//               saturation, timeout, same-cycle issue/retire and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_tracker;
    import axi_monitor_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid_i;
    logic [3:0] req_id_i;
    logic       req_ready_o;
    logic       rsp_valid_i;
    logic [3:0] rsp_id_i;
    logic       timeout_o;
    logic [3:0] timeout_id_o;
    logic       unexp_rsp_o;
    logic       full_o;

    int checks = 0;
    int errors = 0;

    id_tracker dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_id_i     (req_id_i),
        .req_ready_o  (req_ready_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_id_i     (rsp_id_i),
        .timeout_o    (timeout_o),
        .timeout_id_o (timeout_id_o),
        .unexp_rsp_o  (unexp_rsp_o),
        .full_o       (full_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       rv;
        logic [3:0] rid;
        logic       sv;
        logic [3:0] sid;
        logic       ready;
        logic       full;
        logic       to;
        logic       unexp;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [3:0] rid,
                         input logic sv, input logic [3:0] sid);
        req_valid_i = rv;
        req_id_i    = rid;
        rsp_valid_i = sv;
        rsp_id_i    = sid;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    function automatic entry_t snap0();
        entry_t s;
        s.id    = dut.g_entry[0].u_entry.r_id;
        s.free  = dut.g_entry[0].u_entry.r_free;
        s.cnt   = dut.g_entry[0].u_entry.r_cnt;
        s.timer = dut.g_entry[0].u_entry.r_timer;
        return s;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " ready"},   int'(req_ready_o),  1);
        check({tag, " full"},    int'(full_o),       0);
        check({tag, " timeout"}, int'(timeout_o),    0);
        check({tag, " tid"},     int'(timeout_id_o), 0);
        check({tag, " unexp"},   int'(unexp_rsp_o),  0);
    endtask

    initial begin
        entry_t exp_e;
        int     first_k;
        int     n_to;
        int     n_unexp;
        int     got_tid;

        //            rv   rid   sv   sid   ready full to unexp
        vecs[0]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 4'd4, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 4'd5, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 4'd2, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 4'd0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 4'd0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[22] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[23] = '{1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        drive(1'b0, 4'd0, 1'b0, 4'd0);
        #1;
        rst_i = 1'b1;
        #2;
        check_reset_outputs("in_reset");
        do_reset();
        check_reset_outputs("after_reset");

        // ---------------- table of directed vectors ----------------
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].rv, vecs[i].rid, vecs[i].sv, vecs[i].sid);
            #1;
            check($sformatf("v%0d ready", i), int'(req_ready_o), int'(vecs[i].ready));
            check($sformatf("v%0d full", i),  int'(full_o),      int'(vecs[i].full));
            check($sformatf("v%0d timeout", i), int'(timeout_o), int'(vecs[i].to));
            check($sformatf("v%0d unexp", i), int'(unexp_rsp_o), int'(vecs[i].unexp));
            tick();
        end

        // ---------------- first allocation lands in entry 0 ----------------
        do_reset();
        drive(1'b1, 4'd3, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        exp_e = '{id: 4'd3, free: 1'b0, cnt: 3'd1, timer: 8'd16};
        check("alloc entry0", int'(snap0()), int'(exp_e));

        // ---------------- counter saturation ----------------
        do_reset();
        drive(1'b1, 4'd7, 1'b0, 4'd0);
        repeat (7) tick();
        drive(1'b1, 4'd7, 1'b0, 4'd0);
        #1;
        check("sat ready id7", int'(req_ready_o), 0);
        tick();
        check("sat cnt held", int'(snap0().cnt), 7);
        drive(1'b0, 4'd7, 1'b1, 4'd7);
        tick();
        drive(1'b0, 4'd7, 1'b0, 4'd0);
        #1;
        check("sat ready after rsp", int'(req_ready_o), 1);
        check("sat cnt after rsp", int'(snap0().cnt), 6);

        // ---------------- budget timeout ----------------
        do_reset();
        drive(1'b1, 4'd2, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        first_k = 0;
        n_to    = 0;
        got_tid = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (timeout_o) begin
                n_to++;
                if (first_k == 0) begin
                    first_k = k;
                    got_tid = int'(timeout_id_o);
                end
            end
        end
        check("timeout cycle", first_k, 16);
        check("timeout pulses", n_to, 1);
        check("timeout id", got_tid, 2);
        check("expired still live", int'(snap0().free), 0);
        drive(1'b0, 4'd0, 1'b1, 4'd2);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        check("expired rsp unexp", int'(unexp_rsp_o), 0);
        check("expired rsp frees", int'(snap0().free), 1);

        // ---------------- same-cycle issue and retire, then reset ----------------
        do_reset();
        drive(1'b1, 4'd6, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd6, 1'b1, 4'd6);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        exp_e = '{id: 4'd6, free: 1'b0, cnt: 3'd1, timer: 8'd16};
        check("same-cycle entry", int'(snap0()), int'(exp_e));
        check("same-cycle unexp", int'(unexp_rsp_o), 0);
        drive(1'b1, 4'd6, 1'b0, 4'd0);
        tick();
        drive(1'b1, 4'd9, 1'b0, 4'd0);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        exp_e = '{id: 4'd0, free: 1'b1, cnt: 3'd0, timer: 8'd0};
        check("mid_reset entry0", int'(snap0()), int'(exp_e));
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        n_to    = 0;
        n_unexp = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            if (timeout_o) n_to++;
            if (unexp_rsp_o) n_unexp++;
        end
        check("post-reset timeouts", n_to, 0);
        check("post-reset unexp", n_unexp, 0);
        check_reset_outputs("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_id_tracker
`default_nettype wire
